// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the 8N1 UART receiver: byte width and sampling helpers.
package uart_receiver_pkg;

  localparam int BYTE_LEN = 8;

  typedef logic [BYTE_LEN-1:0] byte_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take on reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver with one-cycle data_valid / frame_err pulses.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting at each sample point.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int BAUD_PERIOD_LOG2 = 9,
  parameter int BAUD_PERIOD      = 434
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  output logic [BYTE_LEN-1:0] data,
  output logic                data_valid,
  output logic                frame_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam int CW   = BAUD_PERIOD_LOG2 + 1;
  localparam int BCW  = $clog2(BYTE_LEN);
  localparam int HALF = BAUD_PERIOD / 2;

  // Majority voting decides one cycle after the nominal mid-start point; that
  // single shift carries through every later sample since counters restart there.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_TGT = HALF;
`else
  localparam int START_TGT = HALF - 1;
`endif

  localparam logic [CW-1:0]  START_LAST = CW'(START_TGT);
  localparam logic [CW-1:0]  BIT_LAST   = CW'(BAUD_PERIOD - 1);
  localparam logic [BCW-1:0] BCNT_LAST  = BCW'(BYTE_LEN - 1);

  logic rxd_s;
  logic sample;

  logic [2:0]          state_d, state_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic [BCW-1:0]      bcnt_d, bcnt_q;
  logic [BYTE_LEN-1:0] shift_d, shift_q;
  logic [BYTE_LEN-1:0] data_d, data_q;
  logic                valid_d, valid_q;
  logic                err_d, err_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_d, hist_q;

  always_comb begin
    hist_d = {hist_q[0], rxd_s};
    sample = maj3(rxd_s, hist_q[0], hist_q[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) hist_q <= '1;
    else       hist_q <= hist_d;
  end
`else
  always_comb sample = rxd_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d  = '0;
          bcnt_d = '0;
          state_d = sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[BYTE_LEN-1:1]};
          if (bcnt_q == BCNT_LAST) state_d = ST_STOP;
          else                     bcnt_d  = bcnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated cycle by cycle on rxd
// and expected pulses (kind, byte, arrival cycle) are queued for a monitor.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int BP   = 21;
  localparam int HALF = BP / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Cycles from driving the start-bit edge to the pulse being visible.
  localparam int LAT = 2 + HALF + (BYTE_LEN + 1) * BP + 1 + MAJ;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                rxd = 1'b1;
  logic [BYTE_LEN-1:0] data;
  logic                data_valid;
  logic                frame_err;

  ev_t         sb[$];
  ev_t         e;
  int          checks = 0;
  int          failures = 0;
  int          events = 0;
  int unsigned cyc = 0;
  logic [7:0]  last_good = 8'h00;

  uart_receiver #(.BAUD_PERIOD_LOG2(4), .BAUD_PERIOD(BP)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid || frame_err) begin
      events++;
      checks++;
      if (data_valid && frame_err) begin
        failures++;
        $display("FAIL both_pulses: data_valid=1 frame_err=1 at cycle %0d, required exclusive", cyc);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%02h at cycle %0d, required no pulse",
                 data_valid, frame_err, data, cyc);
      end else begin
        e = sb.pop_front();
        if (frame_err !== e.err || data !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL rx_event: actual err=%0b data=%02h cycle=%0d, required err=%0b data=%02h cycle=%0d",
                   frame_err, data, cyc, e.err, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Caller is always #1 after a posedge; each call leaves it there again.
  task automatic hold(input int n, input logic v);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives ncyc cycles of a frame (start, 8 data LSB first, stop). glitch_bit>=0
  // inverts that data bit for one cycle at its midpoint.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit,
                            input int ncyc, input bit push);
    logic [7:0] expb;
    int bi;
    int off;
    logic v;
    if (push) begin
      expb = b;
      if (glitch_bit >= 0 && MAJ == 0) expb[glitch_bit] = ~expb[glitch_bit];
      if (stop) begin
        sb.push_back('{err: 1'b0, data: expb, cyc: cyc + LAT});
        last_good = expb;
      end else begin
        sb.push_back('{err: 1'b1, data: last_good, cyc: cyc + LAT});
      end
    end
    for (int c = 0; c < ncyc; c++) begin
      bi  = c / BP;
      off = c % BP;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = stop;
      if (glitch_bit >= 0 && bi - 1 == glitch_bit && off == HALF) v = ~v;
      rxd = v;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int ev0;
    logic [7:0] rb;
    logic       rs;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    hold(2 * BP, 1'b1);

    send_frame(8'hA5, 1'b1, -1, 10 * BP, 1'b1);
    hold(BP, 1'b1);

    send_frame(8'h00, 1'b1, -1, 10 * BP, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 10 * BP, 1'b1);
    send_frame(8'h3C, 1'b1, -1, 10 * BP, 1'b1);
    hold(BP, 1'b1);
    chk("b2b_drained", 32'(sb.size()), 32'h0);

    ev0 = events;
    hold(HALF / 2, 1'b0);
    hold(3 * BP, 1'b1);
    chk("false_start_no_pulse", 32'(events), 32'(ev0));

    ev0 = events;
    send_frame(8'h55, 1'b0, -1, 10 * BP, 1'b1);
    hold(5000, 1'b0);
    chk("break_single_pulse", 32'(events), 32'(ev0 + 1));
    chk("break_data_held", 32'(data), 32'(last_good));
    hold(2 * BP, 1'b1);
    send_frame(8'h12, 1'b1, -1, 10 * BP, 1'b1);
    hold(BP, 1'b1);

    chk("pre_reset_drained", 32'(sb.size()), 32'h0);
    send_frame(8'h81, 1'b1, -1, 5 * BP + HALF, 1'b0);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    last_good = 8'h00;
    chk("midframe_reset_data", 32'(data), 32'h0);
    chk("midframe_reset_valid", 32'(data_valid), 32'h0);
    chk("midframe_reset_err", 32'(frame_err), 32'h0);
    ev0 = events;
    hold(2 * BP, 1'b1);
    chk("midframe_reset_no_pulse", 32'(events), 32'(ev0));
    send_frame(8'h81, 1'b1, -1, 10 * BP, 1'b1);
    hold(BP, 1'b1);

    send_frame(8'hF0, 1'b1, 2, 10 * BP, 1'b1);
    hold(BP, 1'b1);

    for (int i = 0; i < 14; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, -1, 10 * BP, 1'b1);
      if (rs) hold($urandom_range(0, 2 * BP), 1'b1);
      else    hold($urandom_range(BP, 3 * BP), 1'b1);
    end

    hold(2 * BP, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
